// File: rtl/camera_emu_pkg.sv
// Shared types, pattern codes and helpers for the camera frame emulator.
package camera_emu_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFvLead,
        StActive,
        StHblank,
        StFvTrail,
        StVblank
    } cam_state_e;

    localparam logic [1:0] PAT_RAMP  = 2'd0;
    localparam logic [1:0] PAT_BARS  = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_CONST = 2'd3;

    // Index of the vertical bar (0..7) that column x falls into for a line of w pixels
    function automatic logic [2:0] pix_bar(input logic [31:0] x, input logic [31:0] w);
        return 3'((x * 32'd8) / w);
    endfunction

endpackage

// File: rtl/camera_emu_pattern.sv
// Combinational test-pattern generator: maps (pattern, x, y, frame) to a 12-bit pixel.
module camera_emu_pattern
    import camera_emu_pkg::*;
#(
    parameter int unsigned ACTIVE_W = 640,
    parameter int unsigned XW       = 10,
    parameter int unsigned YW       = 9
) (
    input  logic [1:0]    pattern,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic [11:0]   f,
    output logic [11:0]   pix
);

    logic [11:0] xe;
    logic [11:0] ye;

    // Zero-extended coordinates so narrow counters still expose bit 3 for the checker
    assign xe = 12'(x);
    assign ye = 12'(y);

    // Select the pixel value for the latched pattern
    always_comb begin
        pix = 12'h000;
        case (pattern)
            PAT_RAMP:  pix = xe + ye + f;
            PAT_BARS:  pix = {pix_bar(32'(x), ACTIVE_W), 9'h1FF};
            PAT_CHECK: pix = (xe[3] ^ ye[3]) ? 12'hFFF : 12'h000;
            default:   pix = 12'h800;
        endcase
    end

endmodule

// File: rtl/camera_frame_emulator.sv
// Parallel camera interface transmitter: generates fval/lval/data frames with
// programmable geometry and selectable test patterns.
module camera_frame_emulator
    import camera_emu_pkg::*;
#(
    parameter int unsigned ACTIVE_W = 640,
    parameter int unsigned ACTIVE_H = 480,
    parameter int unsigned HBLANK   = 16,
    parameter int unsigned FV_LEAD  = 2,
    parameter int unsigned FV_TRAIL = 2,
    parameter int unsigned VBLANK   = 32
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic [11:0] camera_d,
    output logic        camera_fval,
    output logic        camera_lval,
    output logic        frame_done,
    output logic [15:0] frame_count
);

    localparam int unsigned XW    = $clog2(ACTIVE_W);
    localparam int unsigned YW    = $clog2(ACTIVE_H);
    localparam int unsigned MAX_A = (HBLANK > FV_LEAD) ? HBLANK : FV_LEAD;
    localparam int unsigned MAX_B = (FV_TRAIL > VBLANK) ? FV_TRAIL : VBLANK;
    localparam int unsigned MAXP  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned PW    = $clog2(MAXP + 1);

    localparam logic [XW-1:0] X_LAST    = XW'(ACTIVE_W - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(ACTIVE_H - 1);
    localparam logic [PW-1:0] LEAD_LAST = PW'(FV_LEAD - 1);
    localparam logic [PW-1:0] HB_LAST   = PW'(HBLANK - 1);
    localparam logic [PW-1:0] TR_LAST   = PW'(FV_TRAIL - 1);
    localparam logic [PW-1:0] VB_LAST   = PW'(VBLANK - 1);

    cam_state_e    state;
    logic [PW-1:0] phase;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [1:0]    pat;
    logic [15:0]   frame_cnt;
    logic [11:0]   pix_val;

    assign frame_count = frame_cnt;

    camera_emu_pattern #(
        .ACTIVE_W (ACTIVE_W),
        .XW       (XW),
        .YW       (YW)
    ) u_pattern (
        .pattern (pat),
        .x       (x),
        .y       (y),
        .f       (frame_cnt[11:0]),
        .pix     (pix_val)
    );

    // Frame FSM; outputs are registered from the state held during the cycle just ending
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state       <= StIdle;
            phase       <= '0;
            x           <= '0;
            y           <= '0;
            pat         <= PAT_RAMP;
            frame_cnt   <= '0;
            camera_d    <= '0;
            camera_fval <= 1'b0;
            camera_lval <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            camera_fval <= (state != StIdle) && (state != StVblank);
            camera_lval <= (state == StActive);
            camera_d    <= (state == StActive) ? pix_val : 12'h000;
            frame_done  <= 1'b0;
            case (state)
                StIdle: begin
                    if (enable) begin
                        pat   <= pattern_sel;
                        x     <= '0;
                        y     <= '0;
                        phase <= '0;
                        state <= StFvLead;
                    end
                end
                StFvLead: begin
                    if (phase == LEAD_LAST) begin
                        phase <= '0;
                        state <= StActive;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                StActive: begin
                    if (x == X_LAST) begin
                        phase <= '0;
                        state <= (y == Y_LAST) ? StFvTrail : StHblank;
                    end else begin
                        x <= x + 1'b1;
                    end
                end
                StHblank: begin
                    if (phase == HB_LAST) begin
                        phase <= '0;
                        x     <= '0;
                        y     <= y + 1'b1;
                        state <= StActive;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                StFvTrail: begin
                    if (phase == TR_LAST) begin
                        phase <= '0;
                        state <= StVblank;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                StVblank: begin
                    // First vblank cycle: the fval fall and the done pulse share this edge
                    if (phase == '0) begin
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 1'b1;
                    end
                    if (phase == VB_LAST) begin
                        phase <= '0;
                        if (enable) begin
                            pat   <= pattern_sel;
                            x     <= '0;
                            y     <= '0;
                            state <= StFvLead;
                        end else begin
                            state <= StIdle;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_camera_frame_emulator.sv
// Self-checking bench: a frame-timeline model checks both DUTs every cycle, and
// directed checks pin the model against hand-computed frame geometry and pixels.
module tb_camera_frame_emulator;

    localparam int W0 = 8;
    localparam int H0 = 4;
    localparam int W1 = 32;
    localparam int H1 = 9;
    localparam int HB = 3;
    localparam int LD = 2;
    localparam int TR = 2;
    localparam int VB = 5;
    localparam int CAPN = 400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en0 = 1'b0;
    logic        en1 = 1'b0;
    logic [1:0]  ps0 = 2'd0;
    logic [1:0]  ps1 = 2'd0;
    logic [11:0] d0, d1;
    logic        fv0, fv1, lv0, lv1, dn0, dn1;
    logic [15:0] cnt0, cnt1;

    always #5 clk = ~clk;

    camera_frame_emulator #(
        .ACTIVE_W (W0), .ACTIVE_H (H0), .HBLANK (HB),
        .FV_LEAD (LD), .FV_TRAIL (TR), .VBLANK (VB)
    ) dut0 (
        .clk_clk (clk), .reset_reset (rst), .enable (en0), .pattern_sel (ps0),
        .camera_d (d0), .camera_fval (fv0), .camera_lval (lv0),
        .frame_done (dn0), .frame_count (cnt0)
    );

    camera_frame_emulator #(
        .ACTIVE_W (W1), .ACTIVE_H (H1), .HBLANK (HB),
        .FV_LEAD (LD), .FV_TRAIL (TR), .VBLANK (VB)
    ) dut1 (
        .clk_clk (clk), .reset_reset (rst), .enable (en1), .pattern_sel (ps1),
        .camera_d (d1), .camera_fval (fv1), .camera_lval (lv1),
        .frame_done (dn1), .frame_count (cnt1)
    );

    // ---------------- model ----------------
    int          ms[2] = '{-1, -1};      // position in the frame timeline, -1 when idle
    logic [1:0]  mpat[2] = '{2'd0, 2'd0};
    logic [15:0] mcnt[2] = '{16'd0, 16'd0};
    logic [30:0] exp_v[2] = '{31'd0, 31'd0};
    int          wrap_epoch = 0;
    int          seen_epoch = 0;

    function automatic logic [11:0] model_pix(input logic [1:0] pat, input int x, input int y,
                                              input int f, input int w);
        int bar;
        case (pat)
            2'd0: return 12'((x + y + f) % 4096);
            2'd1: begin
                bar = (x * 8) / w;
                return 12'(bar * 512 + 511);
            end
            2'd2: return ((((x / 8) % 2) ^ ((y / 8) % 2)) != 0) ? 12'hFFF : 12'h000;
            default: return 12'h800;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int w, h, actn, fr, per, u, ll;
        logic fv, lv, dn, e;
        logic [11:0] dd;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                ms[k] = -1;
                mpat[k] = 2'd0;
                mcnt[k] = 16'd0;
                exp_v[k] = 31'd0;
            end else begin
                if (k == 0 && wrap_epoch != seen_epoch) begin
                    mcnt[0] = 16'hFFFF;
                    seen_epoch = wrap_epoch;
                end
                w = (k == 0) ? W0 : W1;
                h = (k == 0) ? H0 : H1;
                ll = w + HB;
                actn = h * w + (h - 1) * HB;
                fr = LD + actn + TR;
                per = fr + VB;
                fv = (ms[k] >= 0) && (ms[k] < fr);
                lv = 1'b0;
                dd = 12'h000;
                if (ms[k] >= LD && ms[k] < LD + actn) begin
                    u = ms[k] - LD;
                    if (u % ll < w) begin
                        lv = 1'b1;
                        dd = model_pix(mpat[k], u % ll, u / ll, int'(mcnt[k][11:0]), w);
                    end
                end
                dn = (ms[k] == fr);
                if (dn) mcnt[k] = mcnt[k] + 16'd1;
                exp_v[k] = {fv, lv, dd, dn, mcnt[k]};
                e = (k == 0) ? en0 : en1;
                if (ms[k] < 0 || ms[k] == per - 1) begin
                    if (e) begin
                        ms[k] = 0;
                        mpat[k] = (k == 0) ? ps0 : ps1;
                    end else begin
                        ms[k] = -1;
                    end
                end else begin
                    ms[k] = ms[k] + 1;
                end
            end
        end
    end

    // ---------------- checking and capture ----------------
    int n_chk = 0;
    int n_pass = 0;
    int ncap = 0;
    logic        cf[2][CAPN];
    logic        cl[2][CAPN];
    logic        cdn[2][CAPN];
    logic [11:0] cd[2][CAPN];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    endtask

    task automatic step();
        @(negedge clk);
        chk("model0", {1'b0, fv0, lv0, d0, dn0, cnt0}, {1'b0, exp_v[0]});
        chk("model1", {1'b0, fv1, lv1, d1, dn1, cnt1}, {1'b0, exp_v[1]});
        if (ncap < CAPN) begin
            cf[0][ncap] = fv0; cl[0][ncap] = lv0; cd[0][ncap] = d0; cdn[0][ncap] = dn0;
            cf[1][ncap] = fv1; cl[1][ncap] = lv1; cd[1][ncap] = d1; cdn[1][ncap] = dn1;
            ncap++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Capture index of the n-th rising edge of lval (use_l) or fval, -1 if absent
    function automatic int nth_rise(input int k, input bit use_l, input int n);
        int c = 0;
        logic prev = 1'b0;
        logic cur;
        for (int i = 0; i < ncap; i++) begin
            cur = use_l ? cl[k][i] : cf[k][i];
            if (cur && !prev) begin
                if (c == n) return i;
                c++;
            end
            prev = cur;
        end
        return -1;
    endfunction

    function automatic int count_rises(input int k, input bit use_l);
        int c = 0;
        logic prev = 1'b0;
        logic cur;
        for (int i = 0; i < ncap; i++) begin
            cur = use_l ? cl[k][i] : cf[k][i];
            if (cur && !prev) c++;
            prev = cur;
        end
        return c;
    endfunction

    function automatic int count_fval(input int k);
        int c = 0;
        for (int i = 0; i < ncap; i++) if (cf[k][i]) c++;
        return c;
    endfunction

    function automatic int count_done(input int k);
        int c = 0;
        for (int i = 0; i < ncap; i++) if (cdn[k][i]) c++;
        return c;
    endfunction

    // ---------------- directed scenarios ----------------
    initial begin
        int r;
        repeat (3) step();
        chk("reset_outputs", {fv0, lv0, d0, dn0, cnt0}, 32'd0);
        rst = 1'b0;

        // Single frame, ramp
        ps0 = 2'd0; en0 = 1'b1; ncap = 0;
        step();
        en0 = 1'b0;
        repeat (59) step();
        chk("t1_fval_len", count_fval(0), 45);
        chk("t1_fval_rises", count_rises(0, 1'b0), 1);
        chk("t1_lval_pulses", count_rises(0, 1'b1), 4);
        chk("t1_line_pitch", nth_rise(0, 1'b1, 1) - nth_rise(0, 1'b1, 0), 11);
        r = nth_rise(0, 1'b1, 0);
        chk("t1_line0_start", r, 3);
        if (r >= 0 && r + 8 < ncap)
            for (int i = 0; i < 8; i++) chk("t1_line0_pix", cd[0][r + i], i);
        chk("t1_done_pulses", count_done(0), 1);
        chk("t1_done_at", cdn[0][46], 1);
        chk("t1_count", cnt0, 1);

        // Continuous run
        do_reset();
        ps0 = 2'd0; en0 = 1'b1; ncap = 0;
        repeat (150) step();
        chk("t2_first_rise", nth_rise(0, 1'b0, 0), 1);
        chk("t2_period_a", nth_rise(0, 1'b0, 1) - nth_rise(0, 1'b0, 0), 50);
        chk("t2_period_b", nth_rise(0, 1'b0, 2) - nth_rise(0, 1'b0, 1), 50);
        r = nth_rise(0, 1'b1, 4);
        chk("t2_f2_line0_start", r, 53);
        if (r >= 0 && r + 8 < ncap)
            for (int i = 0; i < 8; i++) chk("t2_f2_line0_pix", cd[0][r + i], i + 1);
        chk("t2_count", cnt0, 3);
        en0 = 1'b0;

        // Mid-frame enable drop and pattern change
        do_reset();
        ps0 = 2'd0; en0 = 1'b1; ncap = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (i == 17) begin
                en0 = 1'b0;
                ps0 = 2'd3;
            end
        end
        chk("t4_fval_rises", count_rises(0, 1'b0), 1);
        chk("t4_fval_len", count_fval(0), 45);
        r = nth_rise(0, 1'b1, 1);
        chk("t4_line1_start", r, 14);
        if (r >= 0 && r + 8 < ncap)
            for (int i = 0; i < 8; i++) chk("t4_line1_pix", cd[0][r + i], i + 1);
        chk("t4_count", cnt0, 1);
        en0 = 1'b1; ncap = 0;
        step();
        en0 = 1'b0;
        repeat (29) step();
        r = nth_rise(0, 1'b1, 0);
        chk("t4_restart_line0", r, 3);
        if (r >= 0 && r + 8 < ncap)
            for (int i = 0; i < 8; i++) chk("t4_const_pix", cd[0][r + i], 12'h800);
        repeat (30) step();

        // Checker and bars on the wide instance
        do_reset();
        ps1 = 2'd2; en1 = 1'b1; ncap = 0;
        step();
        en1 = 1'b0;
        repeat (339) step();
        r = nth_rise(1, 1'b1, 0);
        chk("t3_line0_start", r, 3);
        if (r >= 0 && r + 16 < ncap)
            for (int i = 0; i < 16; i++)
                chk("t3_line0_pix", cd[1][r + i], (i < 8) ? 12'h000 : 12'hFFF);
        r = nth_rise(1, 1'b1, 8);
        chk("t3_line8_start", r, 283);
        if (r >= 0 && r + 16 < ncap)
            for (int i = 0; i < 16; i++)
                chk("t3_line8_pix", cd[1][r + i], (i < 8) ? 12'hFFF : 12'h000);
        ps1 = 2'd1; en1 = 1'b1; ncap = 0;
        step();
        en1 = 1'b0;
        repeat (330) step();
        chk("t3_bar_x4", cd[1][3 + 4], 12'h3FF);
        chk("t3_bar_x31", cd[1][3 + 31], 12'hFFF);

        // Reset in the middle of an active line
        do_reset();
        ps0 = 2'd0; en0 = 1'b1;
        repeat (56) step();
        chk("t5_pre_lval", lv0, 1);
        chk("t5_pre_count", cnt0, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_out", {fv0, lv0, d0, dn0}, 32'd0);
        chk("t5_async_count", cnt0, 0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("t5_fval_c1", fv0, 0);
        step();
        chk("t5_fval_c2", fv0, 1);
        en0 = 1'b0;
        repeat (60) step();

        // Frame counter wrap
        do_reset();
        step();
        force dut0.frame_cnt = 16'hFFFF;
        wrap_epoch++;
        step();
        release dut0.frame_cnt;
        step();
        chk("t6_preset", cnt0, 16'hFFFF);
        ps0 = 2'd0; en0 = 1'b1; ncap = 0;
        step();
        en0 = 1'b0;
        repeat (59) step();
        r = nth_rise(0, 1'b1, 0);
        chk("t6_line0_start", r, 3);
        if (r >= 0 && r + 3 < ncap) begin
            chk("t6_pix_x0", cd[0][r], 12'hFFF);
            chk("t6_pix_x1", cd[0][r + 1], 12'h000);
            chk("t6_pix_x2", cd[0][r + 2], 12'h001);
        end
        chk("t6_done_pulses", count_done(0), 1);
        chk("t6_count_wrap", cnt0, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
